// File: rtl/pipeline_pkg.sv
// ----------------------------------------------------------------------------
// pipeline_pkg
// Types and helpers shared by the pipeline stages.
//   data_t / addr_t / reg_id_t / bool_t : basic datapath types
//   mem_size_e                          : BYTE / HALF / WORD access size
//   mem_state_e                         : memory-stage bus FSM states
//   is_misaligned / store_wdata / store_wstrb : access-size helpers
// ----------------------------------------------------------------------------
package pipeline_pkg;

    typedef logic [31:0] data_t;
    typedef logic [31:0] addr_t;
    typedef logic [4:0]  reg_id_t;
    typedef logic        bool_t;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } mem_state_e;

    // Half accesses need an even address, word accesses a 4-byte aligned one.
    // The unused encoding is treated like a word.
    function automatic bool_t is_misaligned(input mem_size_e size, input logic [1:0] offset);
        case (size)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return offset[0];
            default:  return (offset != 2'b00);
        endcase
    endfunction

    // Store data replicated onto every lane it could occupy, so the strobes
    // alone pick the bytes that land in memory.
    function automatic data_t store_wdata(input mem_size_e size, input data_t rs2);
        case (size)
            MEM_BYTE: return {4{rs2[7:0]}};
            MEM_HALF: return {2{rs2[15:0]}};
            default:  return rs2;
        endcase
    endfunction

    function automatic logic [3:0] store_wstrb(input mem_size_e size, input logic [1:0] offset);
        case (size)
            MEM_BYTE: return 4'b0001 << offset;
            MEM_HALF: return 4'b0011 << offset;
            default:  return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// ----------------------------------------------------------------------------
// load_extend
// Picks the addressed byte/half out of a raw aligned memory word and sign- or
// zero-extends it to 32 bits. Purely combinational.
//   rdata       in  32  raw aligned word from memory
//   offset      in  2   address bits [1:0] of the access
//   size        in  2   mem_size_e encoding
//   is_unsigned in  1   1: zero-extend, 0: sign-extend
//   data        out 32  extended load result
// ----------------------------------------------------------------------------
module load_extend
    import pipeline_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // NOTE: every signal assigned in an always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        data     = rdata;
        case (mem_size_e'(size))
            MEM_BYTE: data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
            MEM_HALF: data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
            default:  data = rdata;
        endcase
    end

endmodule

// File: rtl/stage4_memory.sv
// ----------------------------------------------------------------------------
// stage4_memory
// Fourth pipeline stage: issues data-memory loads/stores on a valid/ready bus,
// aligns store data, extends load data and registers the write-back result.
// stall_out holds the upstream stages while an access is in flight.
//
// Parameters
//   CHECK_ALIGN  1: misaligned half/word accesses are dropped and flagged
//   BUS_TIMEOUT  cycles allowed in REQ / WAIT_RSP before a bus error (0 = never)
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   alu_res, rs2_val, rd_idx         execute-stage result / store data / dest
//   mem_load_enable, mem_store_enable, reg_write_enable, mem_size, mem_unsigned
//                                    execute-stage control
//   dmem_req_*                       request channel (valid/ready)
//   dmem_rsp_valid, dmem_rsp_rdata   load response channel
//   stall_out                        combinational upstream hold
//   wb_data_out, rd_idx_out, reg_write_enable_out  registered write-back
//   misaligned_out, bus_error_out    registered one-cycle error pulses
// ----------------------------------------------------------------------------
module stage4_memory
    import pipeline_pkg::*;
#(
    parameter int CHECK_ALIGN = 1,
    parameter int BUS_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] alu_res,
    input  logic [31:0] rs2_val,
    input  logic [4:0]  rd_idx,
    input  logic        mem_load_enable,
    input  logic        mem_store_enable,
    input  logic        reg_write_enable,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_req_write,
    output logic [31:0] dmem_req_addr,
    output logic [31:0] dmem_req_wdata,
    output logic [3:0]  dmem_req_wstrb,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_rdata,
    output logic        stall_out,
    output logic [31:0] wb_data_out,
    output logic [4:0]  rd_idx_out,
    output logic        reg_write_enable_out,
    output logic        misaligned_out,
    output logic        bus_error_out
);

    localparam bit          TMO_EN   = (BUS_TIMEOUT > 0);
    localparam logic [15:0] TMO_LAST = TMO_EN ? 16'(BUS_TIMEOUT - 1) : 16'd0;

    mem_state_e  state_q, state_d;

    // Request fields captured at issue; the execute stage is free to change
    // its outputs while we stall.
    addr_t       lat_addr_q;
    mem_size_e   lat_size_q;
    bool_t       lat_unsigned_q;
    bool_t       lat_write_q;
    bool_t       lat_rwe_q;
    reg_id_t     lat_rd_q;
    data_t       lat_wdata_q;
    logic [3:0]  lat_wstrb_q;

    logic [15:0] tmo_cnt_q;

    mem_size_e   in_size;
    logic        mem_op;
    logic        misaligned;
    logic        tmo_last;
    data_t       load_data;

    // FSM decode results
    logic        idle_issue;
    logic        enter_wait;
    logic        wb_pass;
    logic        load_done;
    logic        flag_misaligned;
    logic        timeout_hit;

    assign in_size    = mem_size_e'(mem_size);
    assign mem_op     = mem_load_enable | mem_store_enable;
    assign misaligned = (CHECK_ALIGN != 0) && is_misaligned(in_size, alu_res[1:0]);
    assign tmo_last   = TMO_EN && (tmo_cnt_q == TMO_LAST);

    load_extend u_load_extend (
        .rdata       (dmem_rsp_rdata),
        .offset      (lat_addr_q[1:0]),
        .size        (lat_size_q),
        .is_unsigned (lat_unsigned_q),
        .data        (load_data)
    );

    // ------------------------------------------------------------------
    // Next state, bus request and stall
    // ------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        dmem_req_valid  = 1'b0;
        dmem_req_write  = mem_store_enable;
        dmem_req_addr   = {alu_res[31:2], 2'b00};
        dmem_req_wdata  = store_wdata(in_size, rs2_val);
        dmem_req_wstrb  = mem_store_enable ? store_wstrb(in_size, alu_res[1:0]) : 4'h0;
        stall_out       = 1'b0;
        idle_issue      = 1'b0;
        enter_wait      = 1'b0;
        wb_pass         = 1'b0;
        load_done       = 1'b0;
        flag_misaligned = 1'b0;
        timeout_hit     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!mem_op) begin
                    wb_pass = 1'b1;
                end else if (misaligned) begin
                    flag_misaligned = 1'b1;
                end else begin
                    dmem_req_valid = 1'b1;
                    idle_issue     = 1'b1;
                    if (!dmem_req_ready) begin
                        state_d   = ST_REQ;
                        stall_out = 1'b1;
                    end else if (!mem_store_enable) begin
                        state_d    = ST_WAIT_RSP;
                        enter_wait = 1'b1;
                        stall_out  = 1'b1;
                    end
                    // accepted store: completes this cycle, no stall
                end
            end

            ST_REQ: begin
                dmem_req_valid = 1'b1;
                dmem_req_write = lat_write_q;
                dmem_req_addr  = {lat_addr_q[31:2], 2'b00};
                dmem_req_wdata = lat_wdata_q;
                dmem_req_wstrb = lat_wstrb_q;
                stall_out      = 1'b1;
                if (dmem_req_ready) begin
                    if (lat_write_q) begin
                        state_d   = ST_IDLE;
                        stall_out = 1'b0;
                    end else begin
                        state_d    = ST_WAIT_RSP;
                        enter_wait = 1'b1;
                    end
                end else if (tmo_last) begin
                    // Abandon the access; dropping the stall lets upstream
                    // move past the failed instruction.
                    timeout_hit = 1'b1;
                    stall_out   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            ST_WAIT_RSP: begin
                stall_out = !dmem_rsp_valid;
                if (dmem_rsp_valid) begin
                    load_done = 1'b1;
                    state_d   = ST_IDLE;
                end else if (tmo_last) begin
                    timeout_hit = 1'b1;
                    stall_out   = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // Request latch
    // ------------------------------------------------------------------
    // NOTE: these are plain flops, not a memory array, so resetting them is
    // cheap and keeps the load path free of X after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_addr_q     <= '0;
            lat_size_q     <= MEM_BYTE;
            lat_unsigned_q <= 1'b0;
            lat_write_q    <= 1'b0;
            lat_rwe_q      <= 1'b0;
            lat_rd_q       <= '0;
            lat_wdata_q    <= '0;
            lat_wstrb_q    <= '0;
        end else if (idle_issue) begin
            lat_addr_q     <= alu_res;
            lat_size_q     <= in_size;
            lat_unsigned_q <= mem_unsigned;
            lat_write_q    <= mem_store_enable;
            lat_rwe_q      <= reg_write_enable;
            lat_rd_q       <= rd_idx;
            lat_wdata_q    <= store_wdata(in_size, rs2_val);
            lat_wstrb_q    <= mem_store_enable ? store_wstrb(in_size, alu_res[1:0]) : 4'h0;
        end
    end

    // ------------------------------------------------------------------
    // Timeout counter: restarts on every entry to REQ or WAIT_RSP
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ST_IDLE || enter_wait || state_d == ST_IDLE) begin
            tmo_cnt_q <= '0;
        end else if (TMO_EN) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    // ------------------------------------------------------------------
    // Write-back registers; anything other than a pass-through or a load
    // completion is a bubble.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_data_out          <= '0;
            rd_idx_out           <= '0;
            reg_write_enable_out <= 1'b0;
            misaligned_out       <= 1'b0;
            bus_error_out        <= 1'b0;
        end else begin
            misaligned_out <= flag_misaligned;
            bus_error_out  <= timeout_hit;
            if (wb_pass) begin
                wb_data_out          <= alu_res;
                rd_idx_out           <= rd_idx;
                reg_write_enable_out <= reg_write_enable;
            end else if (load_done) begin
                wb_data_out          <= load_data;
                rd_idx_out           <= lat_rd_q;
                reg_write_enable_out <= lat_rwe_q;
            end else begin
                reg_write_enable_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stage4_memory.sv
// ----------------------------------------------------------------------------
// tb_stage4_memory
// Directed bench for stage4_memory (CHECK_ALIGN = 1, BUS_TIMEOUT = 4).
// Expected write-backs are queued when a load or ALU op is driven and popped
// whenever the DUT raises reg_write_enable_out.
// ----------------------------------------------------------------------------
module tb_stage4_memory;
    import pipeline_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] alu_res;
    logic [31:0] rs2_val;
    logic [4:0]  rd_idx;
    logic        mem_load_enable;
    logic        mem_store_enable;
    logic        reg_write_enable;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic        dmem_req_write;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_wdata;
    logic [3:0]  dmem_req_wstrb;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rsp_rdata;
    logic        stall_out;
    logic [31:0] wb_data_out;
    logic [4:0]  rd_idx_out;
    logic        reg_write_enable_out;
    logic        misaligned_out;
    logic        bus_error_out;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
    } wb_t;

    wb_t sb[$];
    int  tests = 0;
    int  fails = 0;

    stage4_memory #(
        .CHECK_ALIGN (1),
        .BUS_TIMEOUT (4)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .alu_res              (alu_res),
        .rs2_val              (rs2_val),
        .rd_idx               (rd_idx),
        .mem_load_enable      (mem_load_enable),
        .mem_store_enable     (mem_store_enable),
        .reg_write_enable     (reg_write_enable),
        .mem_size             (mem_size),
        .mem_unsigned         (mem_unsigned),
        .dmem_req_valid       (dmem_req_valid),
        .dmem_req_ready       (dmem_req_ready),
        .dmem_req_write       (dmem_req_write),
        .dmem_req_addr        (dmem_req_addr),
        .dmem_req_wdata       (dmem_req_wdata),
        .dmem_req_wstrb       (dmem_req_wstrb),
        .dmem_rsp_valid       (dmem_rsp_valid),
        .dmem_rsp_rdata       (dmem_rsp_rdata),
        .stall_out            (stall_out),
        .wb_data_out          (wb_data_out),
        .rd_idx_out           (rd_idx_out),
        .reg_write_enable_out (reg_write_enable_out),
        .misaligned_out       (misaligned_out),
        .bus_error_out        (bus_error_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, sample #1 after the edge and retire any write-back.
    task automatic tick();
        wb_t e;
        @(posedge clk);
        #1;
        if (reg_write_enable_out === 1'b1) begin
            tests++;
            assert (sb.size() != 0)
            else begin
                fails++;
                $error("FAIL wb_unexpected: observed rd %0d data %h expected no write-back",
                       rd_idx_out, wb_data_out);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wb_data", wb_data_out, e.data);
                check("wb_rd", 32'(rd_idx_out), 32'(e.rd));
            end
        end
    endtask

    task automatic drive_op(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                            input logic ld, input logic st, input logic rwe,
                            input logic [1:0] size, input logic uns);
        alu_res          = alu;
        rs2_val          = rs2;
        rd_idx           = rd;
        mem_load_enable  = ld;
        mem_store_enable = st;
        reg_write_enable = rwe;
        mem_size         = size;
        mem_unsigned     = uns;
    endtask

    task automatic drive_idle();
        drive_op(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, MEM_BYTE, 1'b0);
    endtask

    // One load: ready held low for ready_wait cycles, response arrives
    // rsp_wait cycles after the accepting cycle.
    task automatic run_load(input string tag, input logic [31:0] addr, input logic [4:0] rd,
                            input logic [1:0] size, input logic uns,
                            input int ready_wait, input int rsp_wait,
                            input logic [31:0] rdata, input logic [31:0] exp_wb);
        wb_t e;
        drive_op(addr, 32'h0, rd, 1'b1, 1'b0, 1'b1, size, uns);
        dmem_req_ready = (ready_wait == 0);
        e.data = exp_wb;
        e.rd   = rd;
        sb.push_back(e);
        #1;
        check({tag, "_req_valid"}, 32'(dmem_req_valid), 32'd1);
        check({tag, "_req_addr"}, dmem_req_addr, {addr[31:2], 2'b00});
        check({tag, "_req_write"}, 32'(dmem_req_write), 32'd0);
        check({tag, "_req_wstrb"}, 32'(dmem_req_wstrb), 32'd0);
        check({tag, "_stall_issue"}, 32'(stall_out), 32'd1);
        for (int i = 0; i < ready_wait; i++) begin
            tick();
            // Upstream inputs are don't-care now; scramble them.
            drive_op(~addr, 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b1, 1'b0, MEM_WORD, 1'b0);
            dmem_req_ready = (i == ready_wait - 1);
            #1;
            check({tag, "_req_hold_valid"}, 32'(dmem_req_valid), 32'd1);
            check({tag, "_req_hold_addr"}, dmem_req_addr, {addr[31:2], 2'b00});
            check({tag, "_req_hold_write"}, 32'(dmem_req_write), 32'd0);
            check({tag, "_stall_req"}, 32'(stall_out), 32'd1);
            check({tag, "_bubble_req"}, 32'(reg_write_enable_out), 32'd0);
        end
        tick();
        dmem_req_ready = 1'b0;
        drive_idle();
        for (int i = 1; i < rsp_wait; i++) begin
            #1;
            check({tag, "_stall_wait"}, 32'(stall_out), 32'd1);
            check({tag, "_valid_wait"}, 32'(dmem_req_valid), 32'd0);
            tick();
        end
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = rdata;
        #1;
        check({tag, "_stall_rsp"}, 32'(stall_out), 32'd0);
        tick();
        check({tag, "_rwe_out"}, 32'(reg_write_enable_out), 32'd1);
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = 32'h0;
    endtask

    initial begin
        rst            = 1'b1;
        dmem_req_ready = 1'b0;
        dmem_rsp_valid = 1'b0;
        dmem_rsp_rdata = 32'h0;
        drive_idle();
        tick();
        tick();

        // Reset state
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_wb_data", wb_data_out, 32'h0);
        check("rst_rd", 32'(rd_idx_out), 32'd0);
        check("rst_rwe", 32'(reg_write_enable_out), 32'd0);
        check("rst_misaligned", 32'(misaligned_out), 32'd0);
        check("rst_bus_error", 32'(bus_error_out), 32'd0);
        check("rst_req_valid", 32'(dmem_req_valid), 32'd0);
        check("rst_stall", 32'(stall_out), 32'd0);

        // 1. ALU pass-through
        begin
            wb_t e;
            drive_op(32'h1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b1, MEM_WORD, 1'b0);
            e.data = 32'h1234;
            e.rd   = 5'd5;
            sb.push_back(e);
            #1;
            check("alu_stall", 32'(stall_out), 32'd0);
            check("alu_req_valid", 32'(dmem_req_valid), 32'd0);
            tick();
            check("alu_rwe_out", 32'(reg_write_enable_out), 32'd1);
        end

        // 2. SW 0x100, accepted immediately
        drive_op(32'h100, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b1, 1'b0, MEM_WORD, 1'b0);
        dmem_req_ready = 1'b1;
        #1;
        check("sw_req_valid", 32'(dmem_req_valid), 32'd1);
        check("sw_req_write", 32'(dmem_req_write), 32'd1);
        check("sw_req_addr", dmem_req_addr, 32'h100);
        check("sw_req_wdata", dmem_req_wdata, 32'hDEAD_BEEF);
        check("sw_req_wstrb", 32'(dmem_req_wstrb), 32'hF);
        check("sw_stall", 32'(stall_out), 32'd0);
        tick();
        dmem_req_ready = 1'b0;
        drive_idle();
        check("sw_bubble", 32'(reg_write_enable_out), 32'd0);

        // 3. LB / LBU at 0x103 with ready delay and late response
        run_load("lb", 32'h103, 5'd7, MEM_BYTE, 1'b0, 2, 3, 32'h8000_0000, 32'hFFFF_FF80);
        run_load("lbu", 32'h103, 5'd8, MEM_BYTE, 1'b1, 2, 3, 32'h8000_0000, 32'h0000_0080);
        run_load("lh", 32'h102, 5'd10, MEM_HALF, 1'b0, 0, 1, 32'h8001_7FFF, 32'hFFFF_8001);
        run_load("lhu", 32'h100, 5'd11, MEM_HALF, 1'b1, 1, 2, 32'h1234_F00D, 32'h0000_F00D);
        run_load("lw", 32'h104, 5'd12, MEM_WORD, 1'b0, 0, 2, 32'hCAFE_0001, 32'hCAFE_0001);

        // 4. SH at 0x102, then misaligned LW at 0x102
        drive_op(32'h102, 32'h0000_ABCD, 5'd0, 1'b0, 1'b1, 1'b0, MEM_HALF, 1'b0);
        dmem_req_ready = 1'b1;
        #1;
        check("sh_req_valid", 32'(dmem_req_valid), 32'd1);
        check("sh_req_addr", dmem_req_addr, 32'h100);
        check("sh_req_wdata", dmem_req_wdata, 32'hABCD_ABCD);
        check("sh_req_wstrb", 32'(dmem_req_wstrb), 32'hC);
        check("sh_stall", 32'(stall_out), 32'd0);
        tick();
        dmem_req_ready = 1'b0;
        drive_op(32'h102, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, MEM_WORD, 1'b0);
        #1;
        check("mis_req_valid", 32'(dmem_req_valid), 32'd0);
        check("mis_stall", 32'(stall_out), 32'd0);
        tick();
        drive_idle();
        check("mis_pulse", 32'(misaligned_out), 32'd1);
        check("mis_bubble", 32'(reg_write_enable_out), 32'd0);
        tick();
        check("mis_pulse_end", 32'(misaligned_out), 32'd0);

        // 5. Timeout after 4 WAIT_RSP cycles without a response
        drive_op(32'h200, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, MEM_WORD, 1'b0);
        dmem_req_ready = 1'b1;
        #1;
        check("tmo_stall_issue", 32'(stall_out), 32'd1);
        tick();
        dmem_req_ready = 1'b0;
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            check("tmo_stall_wait", 32'(stall_out), 32'd1);
            check("tmo_no_error_yet", 32'(bus_error_out), 32'd0);
            tick();
        end
        #1;
        check("tmo_no_error_w4", 32'(bus_error_out), 32'd0);
        tick();
        check("tmo_bus_error", 32'(bus_error_out), 32'd1);
        check("tmo_bubble", 32'(reg_write_enable_out), 32'd0);
        check("tmo_stall_idle", 32'(stall_out), 32'd0);
        check("tmo_req_valid_idle", 32'(dmem_req_valid), 32'd0);
        tick();
        check("tmo_pulse_end", 32'(bus_error_out), 32'd0);

        // 6. Reset during WAIT_RSP, stray response afterwards
        drive_op(32'h300, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, MEM_WORD, 1'b0);
        dmem_req_ready = 1'b1;
        #1;
        tick();
        dmem_req_ready = 1'b0;
        drive_idle();
        rst = 1'b1;
        tick();
        rst            = 1'b0;
        dmem_rsp_valid = 1'b1;
        dmem_rsp_rdata = 32'h1234_5678;
        #1;
        check("rst6_stall", 32'(stall_out), 32'd0);
        check("rst6_req_valid", 32'(dmem_req_valid), 32'd0);
        tick();
        dmem_rsp_valid = 1'b0;
        check("rst6_wb_data", wb_data_out, 32'h0);
        check("rst6_rd", 32'(rd_idx_out), 32'd0);
        check("rst6_rwe", 32'(reg_write_enable_out), 32'd0);
        tick();
        check("rst6_rwe_later", 32'(reg_write_enable_out), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
